// File: rtl/cl_mcl_pkg.sv
// Shared constants and types for the manycore-link rx packet serializer.
package cl_mcl_pkg;

    localparam int rx_word_width_lp = 32;

    typedef enum logic {
        E_RX_IDLE  = 1'b0,
        E_RX_SERVE = 1'b1
    } rx_state_e;

endpackage

// File: rtl/bsg_mcl_pkt_ring.sv
// Circular packet store: write/read pointers wrap modulo els_p (any depth >= 2),
// head packet is read combinationally so it is visible the cycle after its push.
module bsg_mcl_pkt_ring #(
    parameter int width_p = 128,
    parameter int els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         push_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic [width_p-1:0]           head_data_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
    assign wr_ptr_d = (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d = (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    assign count_d  = count_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_d;
            if (pop_i)  rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    assign full_o      = (count_q == cnt_w_lp'(els_p));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bsg_mcl_rx_pkt_serializer.sv
// Buffers wide response packets and emits them as 32-bit words, LSW first.
// Optional occupancy high-water mark is built when BSG_MCL_RX_HWM_EN is defined.
module bsg_mcl_rx_pkt_serializer
    import cl_mcl_pkg::*;
#(
    parameter int pkt_width_p = 128,
    parameter int els_p       = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   pkt_v_i,
    input  logic [pkt_width_p-1:0] pkt_data_i,
    output logic                   pkt_ready_o,
    output logic                   v_o,
    output logic [31:0]            data_o,
    input  logic                   ready_i,
    output logic [31:0]            occupancy_o,
    output logic [31:0]            hwm_o
);
    localparam int words_lp = pkt_width_p / rx_word_width_lp;
    localparam int idx_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic                   push, pop, fire, last_word;
    logic                   full, empty;
    logic [cnt_w_lp-1:0]    count;
    logic [pkt_width_p-1:0] head_data;
    logic [31:0]            head_words [words_lp];

    rx_state_e              state_q;
    logic [idx_w_lp-1:0]    word_idx_q;
    logic [31:0]            occ_q, occ_d;

    bsg_mcl_pkt_ring #(
        .width_p (pkt_width_p),
        .els_p   (els_p)
    ) ring (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_i      (push),
        .data_i      (pkt_data_i),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .head_data_o (head_data)
    );

    for (genvar gi = 0; gi < words_lp; gi++) begin : g_word
        assign head_words[gi] = head_data[gi*rx_word_width_lp +: rx_word_width_lp];
    end

    assign pkt_ready_o = ~full;
    assign push        = pkt_v_i & ~full;
    assign v_o         = (state_q == E_RX_SERVE);
    assign fire        = v_o & ready_i & ~empty;
    assign last_word   = (word_idx_q == idx_w_lp'(words_lp - 1));
    assign pop         = fire & last_word;
    assign data_o      = head_words[word_idx_q];

    assign occ_d = occ_q + (push ? 32'(words_lp) : 32'd0) - (fire ? 32'd1 : 32'd0);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= E_RX_IDLE;
            word_idx_q <= '0;
            occ_q      <= '0;
        end else begin
            occ_q <= occ_d;
            case (state_q)
                E_RX_IDLE: begin
                    if (push) state_q <= E_RX_SERVE;
                end
                E_RX_SERVE: begin
                    if (fire) begin
                        if (last_word) begin
                            word_idx_q <= '0;
                            // Draining the only packet with nothing arriving empties the ring.
                            if (count == cnt_w_lp'(1) && !push) state_q <= E_RX_IDLE;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= E_RX_IDLE;
            endcase
        end
    end

    assign occupancy_o = occ_q;

`ifdef BSG_MCL_RX_HWM_EN
    logic [31:0] hwm_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            hwm_q <= '0;
        end else if (occ_d > hwm_q) begin
            hwm_q <= occ_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = 32'b0;
`endif

endmodule

// File: tb/tb_bsg_mcl_rx_pkt_serializer.sv
// Randomised scoreboard bench: a depth-4 instance for the directed scenarios and a
// depth-3 instance for non-power-of-two wrap, both checked against a word-queue model.
module tb_bsg_mcl_rx_pkt_serializer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n     [2];
    logic         pkt_v     [2];
    logic [127:0] pkt_data  [2];
    logic         pkt_ready [2];
    logic         v         [2];
    logic [31:0]  data      [2];
    logic         rdy       [2];
    logic [31:0]  occ       [2];
    logic [31:0]  hwm       [2];

    logic [31:0]  exp_q [2][$];
    int           hwm_m [2];
    bit           done  [2];
    int           tests;
    int           fails;

    bsg_mcl_rx_pkt_serializer #(.pkt_width_p(128), .els_p(4)) dut (
        .clk_i(clk), .reset_n_i(rst_n[0]),
        .pkt_v_i(pkt_v[0]), .pkt_data_i(pkt_data[0]), .pkt_ready_o(pkt_ready[0]),
        .v_o(v[0]), .data_o(data[0]), .ready_i(rdy[0]),
        .occupancy_o(occ[0]), .hwm_o(hwm[0])
    );

    bsg_mcl_rx_pkt_serializer #(.pkt_width_p(128), .els_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(rst_n[1]),
        .pkt_v_i(pkt_v[1]), .pkt_data_i(pkt_data[1]), .pkt_ready_o(pkt_ready[1]),
        .v_o(v[1]), .data_o(data[1]), .ready_i(rdy[1]),
        .occupancy_o(occ[1]), .hwm_o(hwm[1])
    );

    always #5 clk = ~clk;

    function automatic int els(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %h, required %h", name, k, $time, act, req);
        end
    endtask

    // Reference model: the buffer is just a queue of pending words.
    always @(negedge clk) begin
        int sz;
        int npk;
        logic [31:0] exp_hwm;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                exp_q[k].delete();
                hwm_m[k] = 0;
            end else begin
                sz  = exp_q[k].size();
                npk = (sz + W - 1) / W;
                if (sz > hwm_m[k]) hwm_m[k] = sz;
`ifdef BSG_MCL_RX_HWM_EN
                exp_hwm = 32'(hwm_m[k]);
`else
                exp_hwm = 32'd0;
`endif
                check("occupancy", k, occ[k], 32'(sz));
                check("v", k, 32'(v[k]), 32'(sz != 0));
                check("pkt_ready", k, 32'(pkt_ready[k]), 32'(npk < els(k)));
                check("hwm", k, hwm[k], exp_hwm);
                if (v[k] && rdy[k] && sz > 0) begin
                    check("data", k, data[k], exp_q[k][0]);
                    $display("[TB] dut%0d word %h (expected %h)", k, data[k], exp_q[k][0]);
                    void'(exp_q[k].pop_front());
                end
                if (pkt_v[k] && npk < els(k)) begin
                    for (int w = 0; w < W; w++) exp_q[k].push_back(pkt_data[k][w*32 +: 32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_pkt(input int k, input logic [127:0] d);
        int n;
        n = 0;
        pkt_v[k]    = 1'b1;
        pkt_data[k] = d;
        @(negedge clk);
        while (!pkt_ready[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!pkt_ready[k]) begin
            fails++;
            $display("FAIL accept_timeout dut%0d: pkt_ready=%0b after %0d cycles, required 1", k, pkt_ready[k], n);
        end
        tick();
        pkt_v[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tests++;
        if (exp_q[k].size() != 0) begin
            fails++;
            $display("FAIL drain_timeout dut%0d: %0d words left, required 0", k, exp_q[k].size());
        end
    endtask

    task automatic rand_stream(input int k, input int npkts);
        for (int i = 0; i < npkts; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_pkt(k, rand128());
        end
        done[k] = 1'b1;
    endtask

    task automatic rand_ready(input int k);
        while (!done[k]) begin
            rdy[k] = 1'($urandom_range(0, 1));
            tick();
        end
        rdy[k] = 1'b1;
    endtask

    initial begin
        logic [127:0] held;
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; pkt_v[k] = 1'b0; pkt_data[k] = '0; rdy[k] = 1'b0; done[k] = 1'b0;
        end

        repeat (3) tick();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();

        // Single packet streamed with ready held high
        rdy[0] = 1'b1;
        send_pkt(0, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        drain(0);

        // Fill to capacity, hold off a fifth packet, then drain
        rdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) send_pkt(0, rand128());
        @(negedge clk);
        check("fill_pkt_ready", 0, 32'(pkt_ready[0]), 32'd0);
        check("fill_occupancy", 0, occ[0], 32'd16);
        tick();
        held        = rand128();
        pkt_v[0]    = 1'b1;
        pkt_data[0] = held;
        repeat (3) tick();
        rdy[0] = 1'b1;
        send_pkt(0, held);
        drain(0);

        // Push coinciding with the last-word pop of the only packet
        rdy[0] = 1'b0;
        send_pkt(0, rand128());
        rdy[0] = 1'b1;
        repeat (3) tick();
        send_pkt(0, rand128());
        drain(0);

        // Reset while the head packet is half consumed
        rdy[0] = 1'b0;
        send_pkt(0, rand128());
        rdy[0] = 1'b1;
        repeat (2) tick();
        rdy[0]   = 1'b0;
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        tick();
        rdy[0] = 1'b1;
        send_pkt(0, 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000);
        drain(0);

        // Random traffic on both depths, random ready
        done[0] = 1'b0;
        done[1] = 1'b0;
        fork
            rand_stream(0, 12);
            rand_ready(0);
            rand_stream(1, 10);
            rand_ready(1);
        join
        drain(0);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
